wb_cmd_master: RTL and testbench

//  Single-outstanding Wishbone initiator; the requesting side of the peripheral bus used by misc/e1 register banks.

---
 rtl/wb_cmd_master.sv | 129 ++++++++++++
 tb/tb_wb_cmd_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone initiator, valid/ready command in, completion out
// Optional bus-timeout abort with error counter: define WBM_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int AW      = 8,
  parameter int TMO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] wb_addr,
  output logic [31:0]   wb_wdata,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic [31:0]   wb_rdata,
  input  logic          wb_ack,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t        r_state;
  logic [AW-1:0] r_wb_addr;
  logic [31:0]   r_wb_wdata;
  logic          r_wb_we;
  logic          r_wb_cyc;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;

`ifdef WBM_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_tmo;
  logic          r_rsp_err;
  logic [7:0]    r_err_cnt;

  assign rsp_err = r_rsp_err;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = TMO_CYC[0];
  assign rsp_err      = 1'b0;
  assign err_cnt      = 8'h00;
`endif

  // Reset gates cmd_ready directly so no command is taken while rst is high.
  assign cmd_ready = (r_state == S_IDLE) & ~rst;
  assign wb_addr   = r_wb_addr;
  assign wb_wdata  = r_wb_wdata;
  assign wb_we     = r_wb_we;
  assign wb_cyc    = r_wb_cyc;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wb_addr   <= '0;
      r_wb_wdata  <= 32'h0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
`ifdef WBM_TIMEOUT_EN
      r_tmo       <= '0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_wb_we    <= cmd_we;
            r_wb_addr  <= cmd_addr;
            r_wb_wdata <= cmd_wdata;
            r_wb_cyc   <= 1'b1;
            r_state    <= S_BUS;
`ifdef WBM_TIMEOUT_EN
            r_tmo      <= '0;
`endif
          end
        end
        S_BUS: begin
          // Drop cyc on the edge right after ack: toggling slaves would otherwise ack twice.
          if (wb_ack) begin
            r_wb_cyc    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_wb_we ? 32'h0 : wb_rdata;
            r_state     <= S_RESP;
`ifdef WBM_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
`ifdef WBM_TIMEOUT_EN
          else if (r_tmo == TW'(TMO_CYC - 1)) begin
            r_wb_cyc    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'h01;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master
// Timeout steps run only when WBM_TIMEOUT_EN is defined (TMO_CYC set to 16 here).
module tb_wb_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic [7:0]  err_cnt;

  logic        toggle_mode;
  logic        tb_ack;
  logic        r_ack;

  int n_tests = 0;
  int n_fail  = 0;

  wb_cmd_master #(.AW(8), .TMO_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_rdata  (wb_rdata),
    .wb_ack    (wb_ack),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toggling slave: ack one cycle after it sees cyc, never two in a row.
  always @(posedge clk or posedge rst) begin
    if (rst) r_ack <= 1'b0;
    else     r_ack <= toggle_mode & wb_cyc & ~r_ack;
  end
  assign wb_ack = toggle_mode ? r_ack : tb_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; presents one beat for the next posedge.
  task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d);
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    int ncyc;
    int ok;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; wb_rdata = 32'h0; toggle_mode = 1'b1; tb_ack = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wb_cyc",    wb_cyc,    0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_err_cnt",   err_cnt,   0);
    check("rst_wb_addr",   wb_addr,   0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // Read with a 1-cycle toggling slave.
    wb_rdata = 32'hDEADBEEF;
    issue(1'b0, 8'h07, 32'h0);
    @(negedge clk);
    check("rd_cyc_c1",  wb_cyc,    1);
    check("rd_addr",    wb_addr,   8'h07);
    check("rd_we",      wb_we,     0);
    check("rd_busy",    cmd_ready, 0);
    @(negedge clk);
    check("rd_rsp_c2",  rsp_valid, 0);
    @(negedge clk);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rdata",     rsp_rdata, 32'hDEADBEEF);
    check("rd_err",       rsp_err,   0);
    check("rd_cyc_drop",  wb_cyc,    0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_rsp_done",  rsp_valid, 0);
    check("rd_ready_back", cmd_ready, 1);

    // Write: cyc pulse exactly 2 cycles, data held stable, read data ignored.
    wb_rdata = 32'h12345678;
    issue(1'b1, 8'h02, 32'h000001A5);
    ncyc = 0; ok = 1;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(negedge clk);
      if (wb_cyc) begin
        ncyc++;
        if (!wb_we || wb_wdata != 32'h000001A5 || wb_addr != 8'h02) ok = 0;
      end
    end
    check("wr_cyc_len",  ncyc,      2);
    check("wr_bus_hold", ok,        1);
    check("wr_rsp",      rsp_valid, 1);
    check("wr_rdata",    rsp_rdata, 0);
    check("wr_err",      rsp_err,   0);

    // Response backpressure with a new command waiting.
    cmd_we = 1'b0; cmd_addr = 8'h09; cmd_valid = 1'b1;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata != 32'h0 || rsp_err || cmd_ready || wb_cyc) ok = 0;
    end
    check("stall_hold", ok, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("stall_release", rsp_valid, 0);
    check("stall_ready",   cmd_ready, 1);
    @(negedge clk);
    check("stall_no_cyc",  wb_cyc,    0);

    // Stray ack while idle is ignored.
    toggle_mode = 1'b0; tb_ack = 1'b1;
    repeat (3) @(negedge clk);
    tb_ack = 1'b0;
    check("stray_ack_rsp", rsp_valid, 0);
    check("stray_ack_cyc", wb_cyc,    0);

`ifdef WBM_TIMEOUT_EN
    // Slave never acks: abort after 16 cycles of cyc.
    issue(1'b0, 8'h11, 32'h0);
    ncyc = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      @(negedge clk);
      if (wb_cyc) ncyc++;
    end
    check("tmo_cyc_len", ncyc,      16);
    check("tmo_rsp",     rsp_valid, 1);
    check("tmo_err",     rsp_err,   1);
    check("tmo_rdata",   rsp_rdata, 0);
    check("tmo_err_cnt", err_cnt,   1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Ack arriving in the expiry cycle completes normally.
    wb_rdata = 32'hCAFEF00D;
    issue(1'b0, 8'h12, 32'h0);
    ncyc = 0;
    for (int i = 0; i < 100 && ncyc < 16; i++) begin
      @(negedge clk);
      if (wb_cyc) ncyc++;
    end
    check("exp_reach", ncyc, 16);
    tb_ack = 1'b1;
    @(posedge clk);
    #1 tb_ack = 1'b0;
    @(negedge clk);
    check("exp_rsp",     rsp_valid, 1);
    check("exp_err",     rsp_err,   0);
    check("exp_rdata",   rsp_rdata, 32'hCAFEF00D);
    check("exp_err_cnt", err_cnt,   1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`else
    // Without the timeout a silent slave simply stalls the bus.
    wb_rdata = 32'hCAFEF00D;
    issue(1'b0, 8'h12, 32'h0);
    repeat (40) @(negedge clk);
    check("wait_cyc",  wb_cyc,    1);
    check("wait_rsp",  rsp_valid, 0);
    tb_ack = 1'b1;
    @(posedge clk);
    #1 tb_ack = 1'b0;
    @(negedge clk);
    check("late_rsp",     rsp_valid, 1);
    check("late_rdata",   rsp_rdata, 32'hCAFEF00D);
    check("late_err",     rsp_err,   0);
    check("late_err_cnt", err_cnt,   0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`endif

    // Asynchronous reset in the middle of a bus cycle.
    issue(1'b0, 8'h20, 32'h0);
    @(negedge clk);
    check("arst_cyc_before", wb_cyc, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_cyc_drop",  wb_cyc,    0);
    check("arst_ready_low", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready",   cmd_ready, 1);
    check("arst_rsp",     rsp_valid, 0);
    check("arst_err_cnt", err_cnt,   0);
    @(negedge clk);
    check("arst_cyc_after", wb_cyc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
